// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned ILEN_DEFAULT = 32;

  // Fetch FSM: IDLE may issue, WAIT has one request outstanding,
  // DROP has an outstanding response that must be thrown away.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } if_state_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN_DEFAULT-1:0] instr;
  } fq_entry_t;

  // addi x0, x0, 0 -- presented to decode whenever no entry is valid
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// flush empties the queue in one cycle and takes priority over push/pop.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fq_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;

  // Entry storage; stale contents are harmless since count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues one imem request at a time, queues
// responses with their PCs, and feeds decode over valid/ready.
// Optional performance counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned ILEN     = ILEN_DEFAULT,
  parameter int unsigned FQ_DEPTH = 2,
  parameter int unsigned PC_INC   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr,
  input  logic            id_ready
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] FQ_FULL = CW'(FQ_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   count;
  entry_t          head;
  entry_t          push_data;
  logic            push, pop, fire, q_full;

  assign q_full = (count >= FQ_FULL);

  // Issue only from IDLE with a free slot; reset also holds the request low
  assign imem_req_valid = !rst && (state_q == IDLE) && !q_full && !redirect_valid;
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign pc_next  = redirect_valid ? redirect_pc : pc + XLEN'(PC_INC);
  assign pc_stall = !(fire || redirect_valid);

  assign id_valid = (count != '0) && !redirect_valid;
  assign id_pc    = head.pc;
  assign id_instr = id_valid ? head.instr : ILEN'(NOP_INSTR);
  assign pop      = id_valid && id_ready;

  assign push_data = '{pc: req_pc, instr: imem_rsp_data};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and push decision
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = IDLE;
          push    = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the PC of the request just accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       req_pc <= '0;
    else if (fire) req_pc <= pc;
  end

  if_fetch_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

`ifdef IF_FETCH_PERF_EN
  logic drop_evt;
  assign drop_evt = imem_rsp_valid &&
                    ((state_q == DROP) || ((state_q == WAIT) && redirect_valid));

  // Free-running event counters, wrapping on overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fire)     perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (drop_evt) perf_drop_cnt  <= perf_drop_cnt + 32'd1;
      if (q_full)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: table vectors, directed corner
// sequences, and a randomized run against a queue-based reference model.
module tb_if_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [63:0] pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] pc_next;
  logic        pc_stall;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;
`ifdef IF_FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_unit #(
    .XLEN     (64),
    .ILEN     (32),
    .FQ_DEPTH (DEPTH),
    .PC_INC   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_next        (pc_next),
    .pc_stall       (pc_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_ready       (id_ready)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Misaligned PCs are illegal stimulus
  always @(posedge clk) begin
    if (!rst) assert (pc[1:0] == 2'b00) else $error("misaligned pc %h", pc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    pc             = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_id_valid",  {63'd0, id_valid},       64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Fire one request at addr and return data the following cycle
  task automatic fetch_one(input logic [63:0] addr, input logic [31:0] data);
    pc             = addr;
    imem_req_ready = 1'b1;
    #1;
    chk("fetch_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("fetch_req_addr",  imem_req_addr,           addr);
    @(negedge clk);
    imem_req_ready = 1'b0;
    pc             = addr + 64'd4;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
  endtask

  typedef struct {
    logic [63:0] pc;
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic [63:0] exp_next;
    logic        exp_stall;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  vec_t vt[6];

  // Reference-model state
  ent_t        mq[$];
  bit          m_out;
  bit          m_drop;
  logic [63:0] m_req_pc;
  bit          mem_pend;
  int          mem_wait;

  initial begin
    vt[0] = '{pc: 64'h0,                rv: 1'b0, rpc: 64'h0,                rdy: 1'b1,
              exp_next: 64'h4,                exp_stall: 1'b0, exp_valid: 1'b1};
    vt[1] = '{pc: 64'h100,              rv: 1'b0, rpc: 64'h0,                rdy: 1'b0,
              exp_next: 64'h104,              exp_stall: 1'b1, exp_valid: 1'b1};
    vt[2] = '{pc: 64'hFFFFFFFFFFFFFFFC, rv: 1'b0, rpc: 64'h0,                rdy: 1'b1,
              exp_next: 64'h0,                exp_stall: 1'b0, exp_valid: 1'b1};
    vt[3] = '{pc: 64'h10,               rv: 1'b1, rpc: 64'h1000,             rdy: 1'b1,
              exp_next: 64'h1000,             exp_stall: 1'b0, exp_valid: 1'b0};
    vt[4] = '{pc: 64'h7FFFFFFFFFFFFFFC, rv: 1'b0, rpc: 64'h0,                rdy: 1'b1,
              exp_next: 64'h8000000000000000, exp_stall: 1'b0, exp_valid: 1'b1};
    vt[5] = '{pc: 64'h20,               rv: 1'b1, rpc: 64'hFFFFFFFFFFFFFFF0, rdy: 1'b0,
              exp_next: 64'hFFFFFFFFFFFFFFF0, exp_stall: 1'b0, exp_valid: 1'b0};

    // Table: PC-side outputs from a fresh IDLE state
    for (int i = 0; i < 6; i++) begin
      do_reset();
      pc             = vt[i].pc;
      redirect_valid = vt[i].rv;
      redirect_pc    = vt[i].rpc;
      imem_req_ready = vt[i].rdy;
      #1;
      chk("tbl_pc_next",   pc_next,                   vt[i].exp_next);
      chk("tbl_pc_stall",  {63'd0, pc_stall},         {63'd0, vt[i].exp_stall});
      chk("tbl_req_valid", {63'd0, imem_req_valid},   {63'd0, vt[i].exp_valid});
      if (vt[i].exp_valid) chk("tbl_req_addr", imem_req_addr, vt[i].pc);
    end

    // Basic fetch: response two cycles after accept, visible the cycle after
    do_reset();
    pc = 64'h0;
    imem_req_ready = 1'b1;
    #1;
    chk("s1_req_addr", imem_req_addr, 64'h0);
    chk("s1_pc_next",  pc_next,       64'h4);
    @(negedge clk);
    imem_req_ready = 1'b0;
    pc = 64'h4;
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00000013;
    #1;
    chk("s1_id_valid_early", {63'd0, id_valid}, 64'd0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk("s1_id_valid", {63'd0, id_valid}, 64'd1);
    chk("s1_id_pc",    id_pc,             64'h0);
    chk("s1_id_instr", {32'd0, id_instr}, 64'h13);

    // Queue fills at two entries; third request withheld until a pop
    do_reset();
    fetch_one(64'h0, 32'hAAAA0001);
    fetch_one(64'h4, 32'hAAAA0002);
    pc = 64'h8;
    imem_req_ready = 1'b1;
    #1;
    chk("s2_req_withheld", {63'd0, imem_req_valid}, 64'd0);
    chk("s2_pc_stall",     {63'd0, pc_stall},       64'd1);
    chk("s2_head_pc",      id_pc,                   64'h0);
    chk("s2_head_instr",   {32'd0, id_instr},       64'hAAAA0001);
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    #1;
    chk("s2_req_released", {63'd0, imem_req_valid}, 64'd1);
    chk("s2_req_addr",     imem_req_addr,           64'h8);
    chk("s2_head2_pc",     id_pc,                   64'h4);
    imem_req_ready = 1'b0;

    // Redirect while waiting; late response must be dropped
    do_reset();
    pc = 64'h0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1000;
    #1;
    chk("s3_pc_next",  pc_next,                 64'h1000);
    chk("s3_pc_stall", {63'd0, pc_stall},       64'd0);
    chk("s3_no_req",   {63'd0, imem_req_valid}, 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    pc             = 64'h1000;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD0001;
    #1;
    chk("s3_drop_no_req", {63'd0, imem_req_valid}, 64'd0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk("s3_id_valid", {63'd0, id_valid},       64'd0);
    chk("s3_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("s3_req_addr", imem_req_addr,           64'h1000);

    // Redirect in the same cycle as the response
    do_reset();
    pc = 64'h0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD0002;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    #1;
    chk("s4_pc_next",  pc_next,           64'h2000);
    chk("s4_pc_stall", {63'd0, pc_stall}, 64'd0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    pc             = 64'h2000;
    #1;
    chk("s4_id_valid",  {63'd0, id_valid},       64'd0);
    chk("s4_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("s4_req_addr",  imem_req_addr,           64'h2000);

    // Reset during WAIT; stale response afterwards is ignored
    do_reset();
    pc = 64'h0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD0003;
    #1;
    chk("s6_id_valid0", {63'd0, id_valid}, 64'd0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk("s6_id_valid1",  {63'd0, id_valid},       64'd0);
    chk("s6_req_valid",  {63'd0, imem_req_valid}, 64'd1);

    // Randomized run against the reference model
    do_reset();
    mq.delete();
    m_out    = 0;
    m_drop   = 0;
    m_req_pc = '0;
    mem_pend = 0;
    mem_wait = 0;
    pc       = 64'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        e_req, e_idv, e_stall, fire, pop, rsp;
      logic [63:0] e_next;
      // Memory: answer once its chosen latency elapses
      rsp = 1'b0;
      if (mem_pend) begin
        mem_wait--;
        if (mem_wait == 0) begin
          rsp = 1'b1;
          mem_pend = 0;
        end
      end
      imem_rsp_valid = rsp;
      imem_rsp_data  = $urandom;
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 15) == 0) redirect_pc = 64'hFFFFFFFFFFFFFFFC;
      imem_req_ready = ($urandom_range(0, 9) < 7);
      id_ready       = $urandom_range(0, 1);
      #1;
      e_req   = !m_out && (mq.size() < DEPTH) && !redirect_valid;
      e_idv   = (mq.size() != 0) && !redirect_valid;
      fire    = e_req && imem_req_ready;
      e_next  = redirect_valid ? redirect_pc : pc + 64'd4;
      e_stall = !(fire || redirect_valid);
      chk("rnd_req_valid", {63'd0, imem_req_valid}, {63'd0, e_req});
      chk("rnd_id_valid",  {63'd0, id_valid},       {63'd0, e_idv});
      chk("rnd_pc_next",   pc_next,                 e_next);
      chk("rnd_pc_stall",  {63'd0, pc_stall},       {63'd0, e_stall});
      if (e_req) chk("rnd_req_addr", imem_req_addr, pc);
      if (e_idv) begin
        chk("rnd_id_pc",    id_pc,             mq[0].pc);
        chk("rnd_id_instr", {32'd0, id_instr}, {32'd0, mq[0].instr});
      end
      // Advance the model by one cycle
      pop = e_idv && id_ready;
      if (redirect_valid) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (rsp && m_out && !m_drop) mq.push_back('{pc: m_req_pc, instr: imem_rsp_data});
      end
      if (rsp && m_out) begin
        m_out  = 0;
        m_drop = 0;
      end else if (redirect_valid && m_out) begin
        m_drop = 1;
      end
      if (fire) begin
        m_out    = 1;
        m_req_pc = pc;
        mem_pend = 1;
        mem_wait = $urandom_range(1, 3);
      end
      @(negedge clk);
      if (!e_stall) pc = e_next;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
